// File: rtl/fft_stage_ctrl_if.sv
// Bus bundle between the FFT stage sequencer, its sample source/sink,
// the twiddle ROM and the radix-2 butterfly.
interface fft_stage_ctrl_if #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 17,
  parameter int CWIDTH = 20,
  parameter int LGSPAN = 11
);
  logic                  i_ce;
  logic [2*IWIDTH-1:0]   i_sample;
  logic [LGSPAN-1:0]     o_coef_addr;
  logic [2*CWIDTH-1:0]   i_coef;
  logic                  o_bfly_reset;
  logic                  o_bfly_ce;
  logic [2*IWIDTH-1:0]   o_bfly_left;
  logic [2*IWIDTH-1:0]   o_bfly_right;
  logic [2*CWIDTH-1:0]   o_bfly_coef;
  logic                  o_bfly_aux;
  logic [2*OWIDTH-1:0]   i_bfly_left;
  logic [2*OWIDTH-1:0]   i_bfly_right;
  logic                  i_bfly_aux;
  logic [2*OWIDTH-1:0]   o_sample;
  logic                  o_sync;
  logic                  o_err;

  // The sequencer side.
  modport master (
    input  i_ce, i_sample, i_coef, i_bfly_left, i_bfly_right, i_bfly_aux,
    output o_coef_addr, o_bfly_reset, o_bfly_ce, o_bfly_left, o_bfly_right,
           o_bfly_coef, o_bfly_aux, o_sample, o_sync, o_err
  );

  // The environment side: sample source, ROM, butterfly and sink.
  modport slave (
    output i_ce, i_sample, i_coef, i_bfly_left, i_bfly_right, i_bfly_aux,
    input  o_coef_addr, o_bfly_reset, o_bfly_ce, o_bfly_left, o_bfly_right,
           o_bfly_coef, o_bfly_aux, o_sample, o_sync, o_err
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Sequencer for one radix-2 decimation-in-frequency FFT stage. The first
// half of every frame is parked in an input RAM so each second-half sample
// can be paired with its partner for the butterfly. The butterfly's left
// and right results are then re-serialised: left results stream straight
// out while right results are parked in an output RAM and replayed as the
// second half of the output frame. No arithmetic is done here.
// The interface instance must be built with the same parameters as this
// module.
module fft_stage_ctrl #(
  parameter int IWIDTH = 16,
  parameter int OWIDTH = 17,
  parameter int CWIDTH = 20,
  parameter int LGSPAN = 11
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  fft_stage_ctrl_if.master  bus
);

  localparam int HALF = 1 << LGSPAN;
  localparam logic [LGSPAN:0] ADDR_ONE = {{LGSPAN{1'b0}}, 1'b1};

  typedef enum logic {
    OUT_WAIT,
    OUT_RUN
  } outState_e;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LEFT,
    SEL_MEM
  } sampleSel_e;

  logic [LGSPAN:0]      iAddr_q;
  logic [LGSPAN-1:0]    inIdx;
  logic                 inSecondHalf;
  logic [2*IWIDTH-1:0]  inMem [HALF];
  logic [2*IWIDTH-1:0]  bflyLeft_q;
  logic [2*IWIDTH-1:0]  bflyRight_q;
  logic                 bflyAux_q;

  outState_e            outState_q, outState_d;
  logic [LGSPAN:0]      oAddr_q, oAddr_d;
  logic [LGSPAN-1:0]    outIdx;
  logic                 sync_q, sync_d;
  logic                 err_q, err_d;
  logic [2*OWIDTH-1:0]  sample_q;
  logic [2*OWIDTH-1:0]  outMem [HALF];
  sampleSel_e           sampleSel;
  logic                 outMemWe;
  logic [LGSPAN-1:0]    outMemWaddr;

  assign inIdx        = iAddr_q[LGSPAN-1:0];
  assign inSecondHalf = iAddr_q[LGSPAN];
  assign outIdx       = oAddr_q[LGSPAN-1:0];

  assign bus.o_coef_addr  = inIdx;
  assign bus.o_bfly_reset = !i_reset_n;
  assign bus.o_bfly_ce    = bus.i_ce;
  assign bus.o_bfly_coef  = bus.i_coef;
  assign bus.o_bfly_left  = bflyLeft_q;
  assign bus.o_bfly_right = bflyRight_q;
  assign bus.o_bfly_aux   = bflyAux_q;
  assign bus.o_sample     = sample_q;
  assign bus.o_sync       = sync_q;
  assign bus.o_err        = err_q;

  // Park first-half samples until their second-half partner arrives.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && bus.i_ce && !inSecondHalf) begin
      inMem[inIdx] <= bus.i_sample;
    end
  end

  // Input counter and butterfly operand registers; the stored partner is
  // read here so the ROM twiddle, registered on the same strobe, lines up.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      iAddr_q     <= '0;
      bflyLeft_q  <= '0;
      bflyRight_q <= '0;
      bflyAux_q   <= 1'b0;
    end else if (bus.i_ce) begin
      iAddr_q <= iAddr_q + ADDR_ONE;
      if (inSecondHalf) begin
        bflyLeft_q  <= inMem[inIdx];
        bflyRight_q <= bus.i_sample;
        bflyAux_q   <= (inIdx == '0);
      end else begin
        bflyAux_q   <= 1'b0;
      end
    end
  end

  // Output sequencing: an aux pulse (re)starts a frame, left results go out
  // during the first half while right results are stored, then replayed.
  always_comb begin
    outState_d  = outState_q;
    oAddr_d     = oAddr_q;
    sync_d      = sync_q;
    err_d       = err_q;
    sampleSel   = SEL_HOLD;
    outMemWe    = 1'b0;
    outMemWaddr = outIdx;
    if (bus.i_ce) begin
      if (bus.i_bfly_aux) begin
        if ((outState_q == OUT_RUN) && (oAddr_q != '0)) begin
          err_d = 1'b1;
        end
        outState_d  = OUT_RUN;
        oAddr_d     = ADDR_ONE;
        sync_d      = 1'b1;
        sampleSel   = SEL_LEFT;
        outMemWe    = 1'b1;
        outMemWaddr = '0;
      end else if (outState_q == OUT_RUN) begin
        oAddr_d = oAddr_q + ADDR_ONE;
        sync_d  = 1'b0;
        if (!oAddr_q[LGSPAN]) begin
          sampleSel = SEL_LEFT;
          outMemWe  = 1'b1;
        end else begin
          sampleSel = SEL_MEM;
        end
      end
    end
  end

  // Output state register together with the registered RAM read port.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      outState_q <= OUT_WAIT;
      oAddr_q    <= '0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
      sample_q   <= '0;
    end else begin
      outState_q <= outState_d;
      oAddr_q    <= oAddr_d;
      sync_q     <= sync_d;
      err_q      <= err_d;
      case (sampleSel)
        SEL_LEFT: sample_q <= bus.i_bfly_left;
        SEL_MEM:  sample_q <= outMem[outIdx];
        default:  sample_q <= sample_q;
      endcase
    end
  end

  // Park right results until the second half of the output frame.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && outMemWe) begin
      outMem[outMemWaddr] <= bus.i_bfly_right;
    end
  end

endmodule
